cordic_iter_ctrl: RTL and testbench

- Sequential, area-reduced CORDIC engine.
- Time-multiplexes one X/Y/Z add-sub micro-rotation stage over I clock cycles, where the combinational unit unrolls I stages.
- Adds valid/ready handshakes, quadrant folding for full-circle angles, and gain pre-compensation in trig mode.
- Sits between the trig-consuming datapath and any upstream requester; all data is Q3.29 signed.

---
 rtl/cordic_iter_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: sequential CORDIC engine. One X/Y/Z add-sub micro-rotation
// stage is reused for I clock cycles. Angles anywhere in [-pi, pi] are folded
// into the CORDIC convergence range first. In trig mode the X seed is 1/K, so
// the results have unit magnitude.
// All data is Q3.29 signed. Only N=32 is supported.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready only while idle)
//   trig_rot           1: sin/cos of angle, 0: rotate (Xi,Yi) by angle
//   angle, Xi, Yi      request operands (Xi/Yi ignored in trig mode)
//   out_valid/out_ready result handshake
//   sin, cos           trig-mode results (0 in rotation mode)
//   Xr, Yr             rotation-mode results, scaled by K (0 in trig mode)
//   out_err            angle was outside [-pi, pi]; data outputs are 0
//   busy               engine is not idle
module cordic_iter_ctrl #(
    parameter int N     = 32,
    parameter int I     = 28,
    parameter int CNT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                trig_rot,
    input  logic signed [N-1:0] angle,
    input  logic signed [N-1:0] Xi,
    input  logic signed [N-1:0] Yi,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] sin,
    output logic signed [N-1:0] cos,
    output logic signed [N-1:0] Xr,
    output logic signed [N-1:0] Yr,
    output logic                out_err,
    output logic                busy
);

    localparam logic signed [N-1:0] PI          = 32'sh6487ED51;
    localparam logic signed [N-1:0] NEG_PI      = 32'sh9B7812AF;
    localparam logic signed [N-1:0] HALF_PI     = 32'sh3243F6A9;
    localparam logic signed [N-1:0] NEG_HALF_PI = 32'shCDBC0957;
    localparam logic signed [N-1:0] INV_K       = 32'sh136E9DB4;

    typedef enum logic [1:0] {S_IDLE, S_FOLD, S_ITER, S_DONE} state_t;

    // atan(2^-idx) in Q3.29, rounded to nearest. From idx=10 on, the value
    // rounds to exactly 2^(29-idx).
    function automatic logic signed [N-1:0] atan_rom(input logic [CNT_W-1:0] idx);
        logic signed [N-1:0] v;
        case (idx)
            5'd0:    v = 32'sd421657428;
            5'd1:    v = 32'sd248918915;
            5'd2:    v = 32'sd131521918;
            5'd3:    v = 32'sd66762579;
            5'd4:    v = 32'sd33510843;
            5'd5:    v = 32'sd16771758;
            5'd6:    v = 32'sd8387925;
            5'd7:    v = 32'sd4194219;
            5'd8:    v = 32'sd2097141;
            5'd9:    v = 32'sd1048575;
            default: v = 32'sd524288 >>> (idx - 5'd10);
        endcase
        return v;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  trig_q, trig_d;
    logic signed [N-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [N-1:0]   sin_q, sin_d, cos_q, cos_d, xr_q, xr_d, yr_q, yr_d;
    logic                  err_q, err_d;

    // One micro-rotation; the direction follows the sign of the residual angle.
    logic signed [N-1:0]   x_sh, y_sh, x_rot, y_rot, z_rot, atan_i;
    logic                  d_neg;

    assign x_sh   = x_q >>> cnt_q;
    assign y_sh   = y_q >>> cnt_q;
    assign atan_i = atan_rom(cnt_q);
    assign d_neg  = z_q[N-1];
    assign x_rot  = d_neg ? (x_q + y_sh) : (x_q - y_sh);
    assign y_rot  = d_neg ? (y_q - x_sh) : (y_q + x_sh);
    assign z_rot  = d_neg ? (z_q + atan_i) : (z_q - atan_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    trig_d  = trig_rot;
                    z_d     = angle;
                    x_d     = trig_rot ? INV_K : Xi;
                    y_d     = trig_rot ? '0 : Yi;
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                cnt_d = '0;
                if (z_q > PI || z_q < NEG_PI) begin
                    err_d   = 1'b1;
                    sin_d   = '0;
                    cos_d   = '0;
                    xr_d    = '0;
                    yr_d    = '0;
                    state_d = S_DONE;
                end else begin
                    // Rotating by (angle -/+ pi) and then negating the
                    // vector is the same as rotating by the angle itself.
                    if (z_q > HALF_PI) begin
                        z_d = z_q - PI;
                        x_d = -x_q;
                        y_d = -y_q;
                    end else if (z_q < NEG_HALF_PI) begin
                        z_d = z_q + PI;
                        x_d = -x_q;
                        y_d = -y_q;
                    end
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                x_d   = x_rot;
                y_d   = y_rot;
                z_d   = z_rot;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(I - 1)) begin
                    // Capture the final micro-rotation straight into the
                    // output registers of the active mode.
                    cos_d   = trig_q ? x_rot : '0;
                    sin_d   = trig_q ? y_rot : '0;
                    xr_d    = trig_q ? '0 : x_rot;
                    yr_d    = trig_q ? '0 : y_rot;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    sin_d   = '0;
                    cos_d   = '0;
                    xr_d    = '0;
                    yr_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers: reset to idle with zeroed outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            err_q   <= err_d;
        end
    end

    // Working datapath registers: always reloaded on accept, so no reset.
    always_ff @(posedge clk) begin
        trig_q <= trig_d;
        x_q    <= x_d;
        y_q    <= y_d;
        z_q    <= z_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_err   = err_q;
    assign sin       = sin_q;
    assign cos       = cos_q;
    assign Xr        = xr_q;
    assign Yr        = yr_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Testbench for cordic_iter_ctrl.
// A behavioural job model computes every result with plain integer CORDIC
// arithmetic, using an atan table built from $atan. The bench compares the
// DUT against that model on every cycle. Directed jobs also check against
// ideal $sin/$cos values and hand-derived constants.
module tb_cordic_iter_ctrl;

    localparam int  N     = 32;
    localparam int  I     = 28;
    localparam int  CNT_W = 5;
    localparam real Q     = 536870912.0;
    localparam logic signed [31:0] PI      = 32'sh6487ED51;
    localparam logic signed [31:0] HALF_PI = 32'sh3243F6A9;
    localparam logic signed [31:0] INV_K   = 32'sh136E9DB4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, trig_rot, out_valid, out_ready, out_err, busy;
    logic signed [31:0] angle, Xi, Yi, sin_o, cos_o, xr_o, yr_o;

    cordic_iter_ctrl #(.N(N), .I(I), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .trig_rot(trig_rot), .angle(angle), .Xi(Xi), .Yi(Yi),
        .out_valid(out_valid), .out_ready(out_ready),
        .sin(sin_o), .cos(cos_o), .Xr(xr_o), .Yr(yr_o),
        .out_err(out_err), .busy(busy)
    );

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en   = 0;
    int  atan_tab [I];
    real k_gain;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input logic signed [31:0] act, input real ideal);
        real diff;
        n_checks++;
        diff = $itor(act) - ideal;
        if (diff > 64.0 || diff < -64.0) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0.1f +/-64", name, act, ideal);
        end
    endtask

    // Reference result of one job, from the algorithm's rules.
    function automatic void model_job(input bit trig, input logic signed [31:0] ang,
                                      input logic signed [31:0] xi, input logic signed [31:0] yi,
                                      output bit err, output logic signed [31:0] s,
                                      output logic signed [31:0] c, output logic signed [31:0] xr,
                                      output logic signed [31:0] yr);
        logic signed [31:0] x, y, z, xn, yn;
        s = 0; c = 0; xr = 0; yr = 0;
        err = (ang > PI) || (ang < -PI);
        if (!err) begin
            x = trig ? INV_K : xi;
            y = trig ? 32'sd0 : yi;
            z = ang;
            if (z > HALF_PI) begin
                z = z - PI; x = -x; y = -y;
            end else if (z < -HALF_PI) begin
                z = z + PI; x = -x; y = -y;
            end
            for (int i = 0; i < I; i++) begin
                if (z >= 0) begin
                    xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
                end else begin
                    xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
                end
                x = xn; y = yn;
            end
            if (trig) begin c = x; s = y; end
            else begin xr = x; yr = y; end
        end
    endfunction

    // Transaction-level model: a job is pending for a fixed number of edges,
    // then it waits for the consumer.
    bit  m_busy = 0, m_valid = 0, m_err = 0, m_zero = 0;
    int  m_left = 0;
    logic signed [31:0] m_sin, m_cos, m_xr, m_yr;

    always @(posedge clk) begin : model
        bit e;
        logic signed [31:0] s, c, xr, yr;
        if (rst) begin
            m_busy <= 0; m_valid <= 0; m_left <= 0; m_zero <= 1;
        end else if (!m_busy) begin
            if (in_valid) begin
                model_job(trig_rot, angle, Xi, Yi, e, s, c, xr, yr);
                m_err <= e; m_sin <= s; m_cos <= c; m_xr <= xr; m_yr <= yr;
                m_busy <= 1; m_zero <= 0;
                m_left <= e ? 1 : I + 1;
            end
        end else if (!m_valid) begin
            if (m_left == 1) m_valid <= 1;
            m_left <= m_left - 1;
        end else if (out_ready) begin
            m_busy <= 0; m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("in_ready", in_ready, !m_busy);
            chk1("busy", busy, m_busy);
            chk1("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk1("out_err", out_err, m_err);
                chk("sin", sin_o, m_sin);
                chk("cos", cos_o, m_cos);
                chk("Xr", xr_o, m_xr);
                chk("Yr", yr_o, m_yr);
            end else if (m_zero) begin
                chk1("idle_err", out_err, 1'b0);
                chk("idle_sin", sin_o, 32'h0);
                chk("idle_cos", cos_o, 32'h0);
                chk("idle_Xr", xr_o, 32'h0);
                chk("idle_Yr", yr_o, 32'h0);
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input bit t, input logic signed [31:0] a,
                        input logic signed [31:0] x, input logic signed [31:0] y);
        bit ok, done_f;
        in_valid = 1; trig_rot = t; angle = a; Xi = x; Yi = y;
        done_f = 0;
        for (int k = 0; k < 200 && !done_f; k++) begin
            ok = in_ready;
            @(negedge clk);
            if (ok) done_f = 1;
        end
        in_valid = 0;
        if (!done_f) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected 1");
        end
    endtask

    // n counts cycles with the accept edge as cycle 0 (n=1 right after it).
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic ack;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    function automatic logic signed [31:0] pick_angle();
        logic signed [31:0] a;
        case ($urandom % 12)
            0: a = PI;
            1: a = -PI;
            2: a = PI + 1;
            3: a = -PI - 1;
            4: a = HALF_PI;
            5: a = -HALF_PI;
            6: a = HALF_PI + 1;
            7: a = -HALF_PI - 1;
            8: a = 0;
            9: a = $urandom;
            default: a = int'($urandom_range(0, 32'd3373259426)) - int'(PI);
        endcase
        return a;
    endfunction

    initial begin
        int  n;
        real p, xr_i, yr_i;
        p = 1.0;
        k_gain = 1.0;
        for (int i = 0; i < I; i++) begin
            atan_tab[i] = $rtoi($atan(p) * Q + 0.5);
            k_gain = k_gain * $sqrt(1.0 + p * p);
            p = p / 2.0;
        end
        chk("atan_tab0", atan_tab[0], 32'd421657428);
        chk("atan_tab1", atan_tab[1], 32'd248918915);
        chk("atan_tab27", atan_tab[I-1], 32'd4);

        rst = 1; in_valid = 0; trig_rot = 0; angle = 0; Xi = 0; Yi = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk_en = 1;
        @(negedge clk);

        // Reset in the middle of an iteration phase aborts the job.
        send(1, 32'sh10000000, 0, 0);
        repeat (10) @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        chk1("rst_out_valid", out_valid, 0);
        chk1("rst_in_ready", in_ready, 1);
        chk1("rst_busy", busy, 0);
        chk("rst_data", sin_o | cos_o | xr_o | yr_o, 32'h0);
        repeat (40) @(negedge clk);
        chk1("rst_no_stale", out_valid, 0);

        // Trig mode, angle 0.
        send(1, 32'sh0, 32'sh7FFFFFFF, 32'sh7FFFFFFF);
        wait_valid(n);
        chk("lat_trig0", n, 32'd30);
        chk_tol("trig0_cos", cos_o, 536870912.0);
        chk_tol("trig0_sin", sin_o, 0.0);
        chk("trig0_XrYr", xr_o | yr_o, 32'h0);
        ack();

        // Trig mode, angle = pi via the fold path, then -pi/2.
        send(1, PI, 0, 0);
        wait_valid(n);
        chk_tol("trigpi_cos", cos_o, -536870912.0);
        chk_tol("trigpi_sin", sin_o, 0.0);
        ack();
        send(1, 32'shCDBC0957, 0, 0);
        wait_valid(n);
        chk_tol("trigm90_sin", sin_o, -536870912.0);
        chk_tol("trigm90_cos", cos_o, 0.0);
        ack();

        // Rotation mode: (1,0) by pi/2 gives (0, K).
        send(0, HALF_PI, 32'sh20000000, 32'sh0);
        wait_valid(n);
        chk_tol("rot90_Xr", xr_o, 0.0);
        chk_tol("rot90_Yr", yr_o, 884097681.0);
        chk("rot90_sincos", sin_o | cos_o, 32'h0);
        ack();

        // Out-of-range angle.
        send(1, 32'sh70000000, 0, 0);
        wait_valid(n);
        chk("lat_err", n, 32'd2);
        chk1("err_flag", out_err, 1);
        chk("err_data", sin_o | cos_o | xr_o | yr_o, 32'h0);
        ack();

        // Backpressure with a second request waiting, then back-to-back.
        send(1, 32'sh0C90FDAA, 0, 0);
        wait_valid(n);
        chk("lat_bp", n, 32'd30);
        in_valid = 1; trig_rot = 0; angle = -32'sh20000000;
        Xi = 32'sh18000000; Yi = -32'sh10000000;
        repeat (10) @(negedge clk);
        chk1("bp_hold_valid", out_valid, 1);
        chk1("bp_hold_ready", in_ready, 0);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk1("b2b_ready", in_ready, 1);
        chk1("b2b_valid_drop", out_valid, 0);
        @(negedge clk);
        in_valid = 0;
        chk1("b2b_accepted", busy, 1);
        wait_valid(n);
        chk("lat_b2b", n, 32'd30);
        xr_i = k_gain * (0.75 * $cos(-1.0) + 0.5 * $sin(-1.0)) * Q;
        yr_i = k_gain * (0.75 * $sin(-1.0) - 0.5 * $cos(-1.0)) * Q;
        chk_tol("b2b_Xr", xr_o, xr_i);
        chk_tol("b2b_Yr", yr_o, yr_i);
        ack();

        // Randomized traffic with occasional resets and random backpressure.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom % 500 == 0);
            in_valid  = ($urandom % 3 == 0);
            trig_rot  = $urandom % 2;
            angle     = pick_angle();
            Xi        = int'($urandom_range(0, 32'd1288490188)) - 644245094;
            Yi        = int'($urandom_range(0, 32'd1288490188)) - 644245094;
            out_ready = $urandom % 2;
            @(negedge clk);
        end
        rst = 0; in_valid = 0; out_ready = 1;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
